// File: rtl/switch_injector.sv
`timescale 1ns/1ps
`default_nettype none
// switch_injector: Avalon-MM fed per-port byte queues streamed into three switch ingress ports.
// Optional per-port sent-byte counters are built when SWITCH_INJECTOR_STATS_EN is defined.
module switch_injector #(
  parameter int DEPTH = 16,
  parameter int GAP   = 0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       chipselect,
  input  logic       write,
  input  logic       read,
  input  logic [2:0] address,
  input  logic [7:0] writedata,
  output logic [7:0] readdata,
  output logic [7:0] tx_data1,
  output logic [7:0] tx_data2,
  output logic [7:0] tx_data3,
  output logic       tx_valid1,
  output logic       tx_valid2,
  output logic       tx_valid3,
  input  logic       tx_ready1,
  input  logic       tx_ready2,
  input  logic       tx_ready3
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    PACE = 2'd2
  } state_t;

  logic [2:0]  ready;
  logic [2:0]  valid;
  logic [2:0]  arm;
  logic [2:0]  ovf;
  logic [23:0] data_all;
  logic [23:0] level_all;
  logic [23:0] stat_all;
  logic        ctrl_wr;
  logic        flush;

  assign ready   = {tx_ready3, tx_ready2, tx_ready1};
  assign ctrl_wr = chipselect && write && (address == 3'd3);
  assign flush   = ctrl_wr && writedata[3];

  for (genvar k = 0; k < 3; k++) begin : g_port
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level;
    state_t        state;
    state_t        state_nx;
    logic [7:0]    cnt;
    logic [7:0]    cnt_nx;
    logic          arm_r;
    logic          ovf_r;
    logic          push_req;
    logic          push;
    logic          pop;
    logic          empties;

    assign push_req = chipselect && write && (address == 3'(k));
    // Full check uses the registered level, so a same-edge pop never rescues a push.
    assign push     = push_req && (level != LW'(DEPTH));
    assign pop      = (state == SEND) && ready[k];
    assign empties  = pop && !push && (level == LW'(1));

    always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= writedata;
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
        arm_r  <= 1'b0;
        ovf_r  <= 1'b0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        if (push && !pop)      level <= level + LW'(1);
        else if (pop && !push) level <= level - LW'(1);
        if (push_req && !push)                 ovf_r <= 1'b1;
        else if (ctrl_wr && writedata[4 + k])  ovf_r <= 1'b0;
        // A software arm in the same cycle as the emptying pop wins.
        if (ctrl_wr && writedata[k]) arm_r <= 1'b1;
        else if (empties)            arm_r <= 1'b0;
        if (flush) begin
          wr_ptr <= '0;
          rd_ptr <= '0;
          level  <= '0;
          arm_r  <= 1'b0;
        end
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state <= IDLE;
        cnt   <= 8'd0;
      end else begin
        state <= state_nx;
        cnt   <= cnt_nx;
      end
    end

    always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      case (state)
        IDLE: if (arm_r && level != '0) state_nx = SEND;
        SEND: begin
          if (pop) begin
            if (GAP == 0) begin
              state_nx = (arm_r && level > LW'(1)) ? SEND : IDLE;
            end else begin
              state_nx = PACE;
              cnt_nx   = 8'(GAP - 1);
            end
          end
        end
        PACE: begin
          if (cnt == 8'd0) state_nx = (arm_r && level != '0) ? SEND : IDLE;
          else             cnt_nx   = cnt - 8'd1;
        end
        default: state_nx = IDLE;
      endcase
      if (flush) begin
        state_nx = IDLE;
        cnt_nx   = 8'd0;
      end
    end

`ifdef SWITCH_INJECTOR_STATS_EN
    logic [7:0] sent;
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)   sent <= 8'd0;
      else if (flush) sent <= 8'd0;
      else if (pop)   sent <= sent + 8'd1;
    end
    assign stat_all[8*k +: 8] = sent;
`else
    assign stat_all[8*k +: 8] = 8'd0;
`endif

    assign valid[k]            = (state == SEND);
    assign data_all[8*k +: 8]  = valid[k] ? mem[rd_ptr] : 8'd0;
    assign level_all[8*k +: 8] = 8'(level);
    assign arm[k]              = arm_r;
    assign ovf[k]              = ovf_r;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= 8'd0;
    end else if (chipselect && read) begin
      case (address)
        3'd0:    readdata <= level_all[7:0];
        3'd1:    readdata <= level_all[15:8];
        3'd2:    readdata <= level_all[23:16];
        3'd3:    readdata <= {2'b00, ovf, arm};
        3'd4:    readdata <= stat_all[7:0];
        3'd5:    readdata <= stat_all[15:8];
        3'd6:    readdata <= stat_all[23:16];
        default: readdata <= 8'hA5;
      endcase
    end else begin
      readdata <= 8'd0;
    end
  end

  assign tx_data1  = data_all[7:0];
  assign tx_data2  = data_all[15:8];
  assign tx_data3  = data_all[23:16];
  assign tx_valid1 = valid[0];
  assign tx_valid2 = valid[1];
  assign tx_valid3 = valid[2];

endmodule
`default_nettype wire

// File: tb/tb_switch_injector.sv
`timescale 1ns/1ps
`default_nettype none
// Randomized self-checking bench: two injector instances (DEPTH 4/GAP 0 and DEPTH 8/GAP 3) against a queue model.
module tb_switch_injector;

  localparam int D0 = 4;
  localparam int G0 = 0;
  localparam int D1 = 8;
  localparam int G1 = 3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cs = 1'b0, wr = 1'b0, rd = 1'b0;
  logic [2:0]  addr = 3'd0;
  logic [7:0]  wdata = 8'd0;
  logic [2:0]  rdy0 = 3'd0, rdy1 = 3'd0;
  logic [2:0]  vld0, vld1;
  logic [23:0] d0, d1;
  logic [7:0]  rdd0, rdd1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  switch_injector #(.DEPTH(D0), .GAP(G0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .chipselect(cs), .write(wr), .read(rd),
    .address(addr), .writedata(wdata), .readdata(rdd0),
    .tx_data1(d0[7:0]), .tx_data2(d0[15:8]), .tx_data3(d0[23:16]),
    .tx_valid1(vld0[0]), .tx_valid2(vld0[1]), .tx_valid3(vld0[2]),
    .tx_ready1(rdy0[0]), .tx_ready2(rdy0[1]), .tx_ready3(rdy0[2])
  );

  switch_injector #(.DEPTH(D1), .GAP(G1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .chipselect(cs), .write(wr), .read(rd),
    .address(addr), .writedata(wdata), .readdata(rdd1),
    .tx_data1(d1[7:0]), .tx_data2(d1[15:8]), .tx_data3(d1[23:16]),
    .tx_valid1(vld1[0]), .tx_valid2(vld1[1]), .tx_valid3(vld1[2]),
    .tx_ready1(rdy1[0]), .tx_ready2(rdy1[1]), .tx_ready3(rdy1[2])
  );

  // Reference model: byte queues plus a "presenting" flag and a pacing countdown per port.
  logic [7:0] mq    [2][3][$];
  logic [2:0] marm  [2];
  logic [2:0] movf  [2];
  logic [2:0] mpres [2];
  int         mcool [2][3];
  logic [7:0] mstat [2][3];
  logic [7:0] mrd   [2];

  function automatic int depth_of(input int i);
    return (i == 0) ? D0 : D1;
  endfunction

  function automatic int gap_of(input int i);
    return (i == 0) ? G0 : G1;
  endfunction

  task automatic model_step(input int i, input logic [2:0] ready);
    int         lvl [3];
    logic [2:0] hs;
    logic [7:0] r;
    for (int p = 0; p < 3; p++) begin
      lvl[p] = mq[i][p].size();
      hs[p]  = mpres[i][p] && ready[p];
    end
    r = 8'd0;
    if (cs && rd) begin
      case (addr)
        3'd0, 3'd1, 3'd2: r = 8'(lvl[addr]);
        3'd3:             r = {2'b00, movf[i], marm[i]};
        3'd4, 3'd5, 3'd6: begin
`ifdef SWITCH_INJECTOR_STATS_EN
          r = mstat[i][addr - 3'd4];
`else
          r = 8'd0;
`endif
        end
        default:          r = 8'hA5;
      endcase
    end
    mrd[i] = r;
    for (int p = 0; p < 3; p++) begin
      if (mpres[i][p]) begin
        if (hs[p]) begin
          if (gap_of(i) == 0) begin
            mpres[i][p] = (lvl[p] > 1) && marm[i][p];
          end else begin
            mpres[i][p] = 1'b0;
            mcool[i][p] = gap_of(i);
          end
        end
      end else if (mcool[i][p] > 0) begin
        mcool[i][p] = mcool[i][p] - 1;
        if (mcool[i][p] == 0) mpres[i][p] = marm[i][p] && (lvl[p] > 0);
      end else begin
        mpres[i][p] = marm[i][p] && (lvl[p] > 0);
      end
      if (hs[p]) begin
        void'(mq[i][p].pop_front());
        mstat[i][p] = mstat[i][p] + 8'd1;
      end
      if (cs && wr && addr == 3'(p)) begin
        if (lvl[p] == depth_of(i)) movf[i][p] = 1'b1;
        else                       mq[i][p].push_back(wdata);
      end
      if (hs[p] && mq[i][p].size() == 0) marm[i][p] = 1'b0;
    end
    if (cs && wr && addr == 3'd3) begin
      marm[i] = marm[i] | wdata[2:0];
      movf[i] = movf[i] & ~wdata[6:4];
      if (wdata[3]) begin
        marm[i] = 3'd0;
        for (int p = 0; p < 3; p++) begin
          mq[i][p].delete();
          mpres[i][p] = 1'b0;
          mcool[i][p] = 0;
          mstat[i][p] = 8'd0;
        end
      end
    end
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        marm[i] = 3'd0; movf[i] = 3'd0; mpres[i] = 3'd0; mrd[i] = 8'd0;
        for (int p = 0; p < 3; p++) begin
          mq[i][p].delete();
          mcool[i][p] = 0;
          mstat[i][p] = 8'd0;
        end
      end
    end else begin
      model_step(0, rdy0);
      model_step(1, rdy1);
    end
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    logic       v;
    logic [7:0] d;
    for (int i = 0; i < 2; i++) begin
      for (int p = 0; p < 3; p++) begin
        v = (i == 0) ? vld0[p] : vld1[p];
        d = (i == 0) ? d0[8*p +: 8] : d1[8*p +: 8];
        check($sformatf("valid_i%0d_p%0d", i, p + 1), {7'd0, v}, {7'd0, mpres[i][p]});
        if (mpres[i][p]) check($sformatf("data_i%0d_p%0d", i, p + 1), d, mq[i][p][0]);
      end
    end
    check("rdata_i0", rdd0, mrd[0]);
    check("rdata_i1", rdd1, mrd[1]);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic bus(input logic c, input logic w, input logic r, input logic [2:0] a, input logic [7:0] dt);
    cs = c; wr = w; rd = r; addr = a; wdata = dt;
  endtask

  task automatic bus_idle();
    bus(1'b0, 1'b0, 1'b0, 3'd0, 8'd0);
  endtask

  initial begin
    int r;
    logic [7:0] ctl;
    bus_idle();
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid0", {5'd0, vld0}, 8'd0);
    check("reset_data0", d0[7:0] | d0[15:8] | d0[23:16], 8'd0);
    check("reset_rdata0", rdd0, 8'd0);
    reset_n = 1'b1;

    // Three bytes streamed back to back on port 1 once armed.
    rdy0 = 3'b111; rdy1 = 3'b111;
    bus(1, 1, 0, 3'd0, 8'h11); cycle();
    bus(1, 1, 0, 3'd0, 8'h22); cycle();
    bus(1, 1, 0, 3'd0, 8'h33); cycle();
    bus(1, 1, 0, 3'd3, 8'h01); cycle();
    bus_idle();
    repeat (12) cycle();
    bus(1, 0, 1, 3'd0, 8'd0); cycle();
    check("lvl1_after_stream", rdd0, 8'h00);
    bus(1, 0, 1, 3'd3, 8'd0); cycle();
    check("ctrl_after_stream", rdd0, 8'h00);

    // Overflow on the 4-deep instance.
    rdy0 = 3'b000; rdy1 = 3'b000;
    for (int k = 0; k < 5; k++) begin
      bus(1, 1, 0, 3'd0, 8'(8'h40 + k)); cycle();
    end
    bus(1, 0, 1, 3'd0, 8'd0); cycle();
    check("lvl1_full", rdd0, 8'd4);
    bus(1, 0, 1, 3'd3, 8'd0); cycle();
    check("ovf_set", rdd0, 8'h08);
    bus(1, 1, 0, 3'd3, 8'h10); cycle();
    bus(1, 0, 1, 3'd3, 8'd0); cycle();
    check("ovf_clear", rdd0, 8'h00);
    bus(1, 1, 0, 3'd3, 8'h08); cycle();
    bus_idle(); cycle();

    // Random traffic with alternating ready pressure.
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 99);
      if (r < 40) begin
        bus(1, 1, 0, 3'($urandom_range(0, 2)), 8'($urandom));
      end else if (r < 48) begin
        ctl = 8'($urandom);
        ctl[7] = 1'b0;
        ctl[3] = ($urandom_range(0, 15) == 0);
        bus(1, 1, 0, 3'd3, ctl);
      end else if (r < 70) begin
        bus(1, 0, 1, 3'($urandom_range(0, 7)), 8'd0);
      end else if (r < 73) begin
        bus(0, 1, 0, 3'($urandom_range(0, 3)), 8'($urandom));
      end else if (r < 75) begin
        bus(1, 1, 0, 3'($urandom_range(4, 7)), 8'($urandom));
      end else begin
        bus_idle();
      end
      for (int p = 0; p < 3; p++) begin
        if ((n / 400) % 2 == 0) begin
          rdy0[p] = ($urandom_range(0, 3) != 0);
          rdy1[p] = ($urandom_range(0, 3) != 0);
        end else begin
          rdy0[p] = ($urandom_range(0, 4) == 0);
          rdy1[p] = ($urandom_range(0, 4) == 0);
        end
      end
      cycle();
    end

    // Asynchronous reset in the middle of a transfer.
    bus(1, 1, 0, 3'd3, 8'h08); cycle();
    rdy0 = 3'b111; rdy1 = 3'b111;
    bus(1, 1, 0, 3'd0, 8'h5A); cycle();
    bus(1, 1, 0, 3'd0, 8'h6B); cycle();
    bus(1, 1, 0, 3'd3, 8'h01); cycle();
    bus(1, 0, 1, 3'd7, 8'd0); cycle();
    bus_idle();
    #2;
    reset_n = 1'b0;
    #1;
    check("async_valid0", {5'd0, vld0}, 8'd0);
    check("async_valid1", {5'd0, vld1}, 8'd0);
    check("async_data", d0[7:0] | d1[7:0], 8'd0);
    check("async_rdata", rdd0 | rdd1, 8'd0);
    cycle();
    reset_n = 1'b1;
    bus(1, 0, 1, 3'd7, 8'd0); cycle();
    check("id_after_reset", rdd0, 8'hA5);
    bus_idle();
    repeat (3) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
